pixel_stream_packer: RTL and testbench

//  Successor to the single-pixel coordinate/colour combinator. Scans a SCREEN_WIDTH x SCREEN_HEIGHT

---
 rtl/vstream_pkg.sv | 24 ++
 rtl/pixel_stream_packer_if.sv | 21 ++
 rtl/vstream_coord_gen.sv | 51 +++++
 rtl/pixel_stream_packer.sv | 141 ++++++++++++++
 tb/tb_pixel_stream_packer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vstream_pkg.sv
// Shared types and helpers for the video-stream blocks.
//   rgb_t / coord_t : pixel colour and raster coordinate at the default widths
//   beat_flags_t    : frame-position flags carried with every output beat
//   last_coord()    : true at the final pixel of a W x H raster
package vstream_pkg;

    localparam int COORD_BITS = 32;
    localparam int RGB_BITS   = 24;

    typedef logic [RGB_BITS-1:0]   rgb_t;
    typedef logic [COORD_BITS-1:0] coord_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } beat_flags_t;

    function automatic logic last_coord(input coord_t x, input coord_t y,
                                        input coord_t w, input coord_t h);
        return (x == w - coord_t'(1)) && (y == h - coord_t'(1));
    endfunction

endpackage

// File: rtl/pixel_stream_packer_if.sv
// Valid/ready video stream carrying packed pixel beats with frame flags.
//   data  : packed beat, lane 0 in the low bits
//   valid : beat present          ready : sink accepts when valid && ready
//   sof   : beat holds pixel (0,0)
//   eol   : beat ends a line      eof   : beat ends the frame
// master drives the stream, slave consumes it.
interface pixel_stream_packer_if #(
    parameter int DATA_BITS = 24
) ();

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 sof;
    logic                 eol;
    logic                 eof;

    modport master (output data, valid, sof, eol, eof, input ready);
    modport slave  (input data, valid, sof, eol, eof, output ready);

endinterface

// File: rtl/vstream_coord_gen.sv
// Raster scan counter: walks x across each line, then y down the frame,
// wrapping from (W-1,H-1) back to (0,0). Moves one pixel per advance pulse.
//   clk, reset : clock, synchronous active-high reset
//   advance    : step to the next pixel this cycle
//   x, y       : current coordinate
//   is_sof     : current pixel is (0,0)
//   is_eol     : current pixel is the last of its line
//   is_eof     : current pixel is the last of the frame
module vstream_coord_gen
    import vstream_pkg::*;
#(
    parameter int DATA_WIDTH    = COORD_BITS,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  is_sof,
    output logic                  is_eol,
    output logic                  is_eof
);

    localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(SCREEN_HEIGHT - 1);
    localparam logic [DATA_WIDTH-1:0] ONE    = DATA_WIDTH'(1);

    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values of the others, matching real hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + ONE;
            end else begin
                x <= x + ONE;
            end
        end
    end

    assign is_sof = (x == '0) && (y == '0);
    assign is_eol = (x == X_LAST);
    assign is_eof = last_coord(coord_t'(x), coord_t'(y),
                               coord_t'(SCREEN_WIDTH), coord_t'(SCREEN_HEIGHT));

endmodule

// File: rtl/pixel_stream_packer.sv
// Scans a SCREEN_WIDTH x SCREEN_HEIGHT raster, reads the colour of each pixel
// from a combinational generator in the same cycle, and packs PIXELS_PER_BEAT
// pixels per beat onto a valid/ready stream with sof/eol/eof flags.
//   clk, reset : clock, synchronous active-high reset
//   en         : scan enable, 0 holds the scan and the partial pack
//   colour_i   : colour of pixel (x_o, y_o)
//   x_o, y_o   : current scan coordinate to the pixel generator
//   out        : packed output stream (master side)
//   frame_cnt  : accepted end-of-frame beats, only with PIXEL_STREAM_FRAME_CNT_EN
module pixel_stream_packer
    import vstream_pkg::*;
#(
    parameter int DATA_WIDTH      = COORD_BITS,
    parameter int RGB_SIZE        = RGB_BITS,
    parameter int SCREEN_WIDTH    = 640,
    parameter int SCREEN_HEIGHT   = 480,
    parameter int PIXELS_PER_BEAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [RGB_SIZE-1:0]   colour_i,
    output logic [DATA_WIDTH-1:0] x_o,
    output logic [DATA_WIDTH-1:0] y_o,
    pixel_stream_packer_if.master out
`ifdef PIXEL_STREAM_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_cnt
`endif
);

    localparam int PPB    = PIXELS_PER_BEAT;
    localparam int LANE_W = (PPB > 1) ? $clog2(PPB) : 1;
    localparam int BEAT_W = PPB * RGB_SIZE;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PPB - 1);

    logic [LANE_W-1:0] lane;
    logic              is_last_lane;
    logic              cap;
    logic              is_sof, is_eol, is_eof;
    logic              lane0_sof;
    logic [BEAT_W-1:0] beat_data;
    logic [BEAT_W-1:0] data_q;
    beat_flags_t       beat_flags;
    beat_flags_t       flags_q;
    logic              valid_q;

    // Only the lane that completes a beat can be blocked by a pending beat;
    // earlier lanes land in the pack register and never stall.
    assign is_last_lane = (lane == LAST_LANE);
    assign cap          = en && (!is_last_lane || !valid_q || out.ready);

    vstream_coord_gen #(
        .DATA_WIDTH    (DATA_WIDTH),
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT)
    ) u_coord (
        .clk     (clk),
        .reset   (reset),
        .advance (cap),
        .x       (x_o),
        .y       (y_o),
        .is_sof  (is_sof),
        .is_eol  (is_eol),
        .is_eof  (is_eof)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            lane <= '0;
        end else if (cap) begin
            lane <= is_last_lane ? '0 : lane + LANE_W'(1);
        end
    end

    generate
        if (PPB > 1) begin : g_pack
            logic [(PPB-1)*RGB_SIZE-1:0] pack;
            logic                        sof_q;

            // NOTE: pack and sof_q carry no reset; clearing the lane counter
            // already discards a partial pack, and lane 0 rewrites both.
            always_ff @(posedge clk) begin
                if (cap && !is_last_lane) begin
                    pack[lane*RGB_SIZE +: RGB_SIZE] <= colour_i;
                    if (lane == '0) begin
                        sof_q <= is_sof;
                    end
                end
            end

            assign beat_data = {colour_i, pack};
            assign lane0_sof = sof_q;
        end else begin : g_single
            assign beat_data = colour_i;
            assign lane0_sof = is_sof;
        end
    endgenerate

    // sof belongs to the lane-0 pixel, eol/eof to the pixel closing the beat.
    always_comb begin
        // NOTE: defaults first so no path leaves a bit unassigned (no latch).
        beat_flags     = '0;
        beat_flags.sof = lane0_sof;
        beat_flags.eol = is_eol;
        beat_flags.eof = is_eof;
    end

    // A new beat may overwrite one being accepted in the same cycle, so a
    // single-lane stream keeps valid high and moves one beat per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            flags_q <= '0;
        end else if (cap && is_last_lane) begin
            valid_q <= 1'b1;
            data_q  <= beat_data;
            flags_q <= beat_flags;
        end else if (out.ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out.data  = data_q;
    assign out.valid = valid_q;
    assign out.sof   = flags_q.sof;
    assign out.eol   = flags_q.eol;
    assign out.eof   = flags_q.eof;

`ifdef PIXEL_STREAM_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (valid_q && out.ready && flags_q.eof) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Bench for pixel_stream_packer on an 8x4 raster with 1, 2 and 4 pixels per
// beat side by side. Each copy has its own stream interface, enable, ready and
// colour generator. The reference model is the raster order itself: expected
// beats are consecutive groups of pixels taken from a running pixel index.
module tb_pixel_stream_packer;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int NCFG = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic en  [NCFG];
    logic rdy [NCFG];
    int   total = 0;
    int   bad   = 0;
    int   hs_cnt [NCFG];

    always #5 clk = ~clk;

    // Combinational pixel generator: top byte mixes x and y, then y, then x.
    function automatic logic [23:0] px(input int x, input int y);
        logic [7:0] mix;
        mix = 8'(x * 37 + y * 11 + 5);
        return {mix, 8'(y), 8'(x)};
    endfunction

    task automatic check(input string name, input int cfg_idx,
                         input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s ppb=%0d got=%0h want=%0h", name, 1 << cfg_idx, got, want);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int PPB = 1 << g;
        localparam int DW  = PPB * 24;

        pixel_stream_packer_if #(.DATA_BITS(DW)) bus ();
        logic [31:0] x, y;
        logic [23:0] colour;
        logic        stalled_ok;
`ifdef PIXEL_STREAM_FRAME_CNT_EN
        logic [15:0] fc;
`endif

        assign colour     = px(int'(x), int'(y));
        assign bus.ready  = rdy[g];
        assign stalled_ok = bus.valid && ((int'(x) % PPB) == PPB - 1);

        pixel_stream_packer #(
            .DATA_WIDTH      (32),
            .RGB_SIZE        (24),
            .SCREEN_WIDTH    (W),
            .SCREEN_HEIGHT   (H),
            .PIXELS_PER_BEAT (PPB)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .en        (en[g]),
            .colour_i  (colour),
            .x_o       (x),
            .y_o       (y),
            .out       (bus)
`ifdef PIXEL_STREAM_FRAME_CNT_EN
            ,
            .frame_cnt (fc)
`endif
        );

        // Expected beats: {sof, eol, eof, data[95:0]}
        logic [98:0] q[$];
        int          next_pix = 0;

        task automatic push_frame();
            for (int b = 0; b < NPIX / PPB; b++) begin
                logic [95:0] d;
                int          last;
                d = '0;
                for (int l = 0; l < PPB; l++) begin
                    int p;
                    p = (next_pix + l) % NPIX;
                    d[l*24 +: 24] = px(p % W, p / W);
                end
                last = (next_pix + PPB - 1) % NPIX;
                q.push_back({(next_pix == 0), (last % W == W - 1), (last == NPIX - 1), d});
                next_pix = (next_pix + PPB) % NPIX;
            end
        endtask

        initial begin : monitor
            logic [98:0] exp_beat;
            logic [95:0] act_data, prev_data;
            logic [2:0]  act_flags, prev_flags;
            logic [31:0] prev_x, prev_y;
            logic        prev_rst, prev_stall, prev_en0;
            int          exp_fc;
            prev_rst   = 1'b0;
            prev_stall = 1'b0;
            prev_en0   = 1'b0;
            exp_fc     = 0;
            prev_data  = '0;
            prev_flags = '0;
            prev_x     = '0;
            prev_y     = '0;
            forever begin
                @(negedge clk);
                act_data  = 96'(bus.data);
                act_flags = {bus.sof, bus.eol, bus.eof};
                if (prev_rst) begin
                    check("reset_valid", g, bus.valid, 1'b0);
                    check("reset_xy", g, {x, y}, 64'd0);
                    check("reset_data", g, act_data, 96'd0);
                    check("reset_flags", g, act_flags, 3'd0);
                end else begin
                    if (prev_stall) begin
                        check("hold_valid", g, bus.valid, 1'b1);
                        check("hold_data", g, act_data, prev_data);
                        check("hold_flags", g, act_flags, prev_flags);
                    end
                    if (prev_en0) begin
                        check("pause_xy", g, {x, y}, {prev_x, prev_y});
                    end
                end
`ifdef PIXEL_STREAM_FRAME_CNT_EN
                check("frame_cnt", g, fc, 16'(exp_fc));
`endif
                if (reset) begin
                    q.delete();
                    next_pix   = 0;
                    exp_fc     = 0;
                    prev_stall = 1'b0;
                    prev_en0   = 1'b0;
                end else begin
                    if (bus.valid && bus.ready) begin
                        hs_cnt[g]++;
                        if (q.size() == 0) push_frame();
                        exp_beat = q.pop_front();
                        check("beat_data", g, act_data, exp_beat[95:0]);
                        check("beat_flags", g, act_flags, exp_beat[98:96]);
                        if (exp_beat[96]) exp_fc++;
                    end
                    prev_stall = bus.valid && !bus.ready;
                    prev_data  = act_data;
                    prev_flags = act_flags;
                    prev_en0   = !en[g];
                    prev_x     = x;
                    prev_y     = y;
                end
                prev_rst = reset;
            end
        end
    end

    task automatic set_all(input logic e, input logic r);
        for (int i = 0; i < NCFG; i++) begin
            en[i]  = e;
            rdy[i] = r;
        end
    endtask

    // Handshakes over a window of posedges; expect cycles/(div*PPB) per copy.
    task automatic window(input string name, input int cycles, input int div);
        int c0 [NCFG];
        @(posedge clk);
        for (int i = 0; i < NCFG; i++) c0[i] = hs_cnt[i];
        repeat (cycles) @(posedge clk);
        for (int i = 0; i < NCFG; i++) begin
            check(name, i, hs_cnt[i] - c0[i], cycles / (div * (1 << i)));
        end
    endtask

    initial begin
        int found;
        set_all(1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        set_all(1'b1, 1'b1);

        // Single-lane copy: first beat one cycle after the first capture,
        // then a beat every cycle.
        @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("ppb1_one_per_cycle", 0, cfg[0].bus.valid, 1'b1);
        end
        window("full_rate_beats", 64, 1);

        // Random enable and backpressure.
        repeat (800) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NCFG; i++) begin
                en[i]  = ($urandom_range(3) != 0);
                rdy[i] = ($urandom_range(2) != 0);
            end
        end

        // Five cycles of backpressure: every copy parks on its last lane.
        @(posedge clk);
        #1;
        set_all(1'b1, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("stall_at_last_lane", 0, cfg[0].stalled_ok, 1'b1);
        check("stall_at_last_lane", 1, cfg[1].stalled_ok, 1'b1);
        check("stall_at_last_lane", 2, cfg[2].stalled_ok, 1'b1);
        @(posedge clk);
        #1;
        set_all(1'b1, 1'b1);
        repeat (20) @(posedge clk);

        // Enable toggling every cycle halves the beat rate.
        fork
            begin
                repeat (96) begin
                    @(posedge clk);
                    #1;
                    for (int i = 0; i < NCFG; i++) en[i] = !en[i];
                end
            end
            begin
                repeat (16) @(posedge clk);
                window("half_rate_beats", 64, 2);
            end
        join
        @(posedge clk);
        #1;
        set_all(1'b1, 1'b1);

        // Reset while the single-lane copy sits at (5,2) with a beat pending.
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(negedge clk);
            if (cfg[0].x == 32'd4 && cfg[0].y == 32'd2) found = 1;
        end
        check("reach_pixel_4_2", 0, found, 1);
        @(posedge clk);
        #1;
        check("at_5_2_valid", 0, {cfg[0].bus.valid, cfg[0].x, cfg[0].y}, {1'b1, 32'd5, 32'd2});
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Several frames at full rate, then random traffic again.
        repeat (400) @(posedge clk);
        repeat (300) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NCFG; i++) begin
                en[i]  = ($urandom_range(3) != 0);
                rdy[i] = ($urandom_range(2) != 0);
            end
        end

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
